command_decoder: RTL and testbench
==================================

COMMAND_DECODER -- requirements
Module: command_decoder

Interface
REQ-001 SHALL have parameter CHALLENGE_BYTES, default 8: number of challenge bytes per frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum idle clk cycles between bytes inside a frame.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe; rx_data valid.
REQ-007 SHALL have port rx_error  input  1  one-cycle UART framing/parity error strobe.
REQ-008 SHALL have port rx_enable  input  1  main state machine permits byte acceptance.
REQ-009 SHALL have port valid_data_in  output  1  one-cycle command-complete strobe to the main state machine.
REQ-010 SHALL have port id_requested  output  1  qualifies valid_data_in as an ID request.
REQ-011 SHALL have port challenge  output  8*CHALLENGE_BYTES  last complete challenge, first received byte in the MSBs.
REQ-012 SHALL have port cmd_error  output  1  one-cycle strobe on an aborted or illegal command.
REQ-013 SHALL have port busy  output  1  high while a challenge frame is being collected.

Function
REQ-014 SHALL implement states IDLE and COLLECT.
REQ-015 SHALL treat a byte as accepted only when rx_valid=1 and rx_enable=1; other rx_valid strobes are discarded with no effect.
REQ-016 In IDLE, an accepted 8'hA5 SHALL assert valid_data_in=1 and id_requested=1 for exactly the next cycle; state stays IDLE.
REQ-017 In IDLE, an accepted 8'h5C SHALL enter COLLECT with byte count 0 and the timeout counter cleared.
REQ-018 In IDLE, any other accepted byte SHALL pulse cmd_error the next cycle; state stays IDLE.
REQ-019 In COLLECT, each accepted byte SHALL shift into a staging register, increment the count and clear the timeout counter.
REQ-020 On the accepted byte that makes count equal to CHALLENGE_BYTES, the block SHALL load challenge from staging, pulse valid_data_in with id_requested=0 the next cycle, and return to IDLE.
REQ-021 challenge SHALL change only on frame completion; aborted frames leave it unchanged.
REQ-022 In COLLECT, the timeout counter SHALL increment each cycle without an accepted byte; on reaching TIMEOUT_CYCLES it SHALL pulse cmd_error and return to IDLE.
REQ-023 rx_error=1 in any state SHALL pulse cmd_error the next cycle and force IDLE; when rx_error and rx_valid coincide, the error wins and the byte is discarded.
REQ-024 Opcode bytes inside COLLECT SHALL be treated as data.
REQ-025 Deassertion of rx_enable in COLLECT SHALL NOT abort the frame; the timeout still runs.
REQ-026 busy SHALL equal (state == COLLECT).
REQ-027 valid_data_in, id_requested and cmd_error SHALL be registered, never asserted together with each other except valid_data_in with id_requested, and never longer than one cycle.
REQ-028 The byte counter SHALL be $clog2(CHALLENGE_BYTES+1) bits wide; the timeout counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and saturate.

Reset
REQ-029 When reset=0, state SHALL be IDLE, counters 0, staging and challenge all-zero, and valid_data_in, id_requested, cmd_error and busy 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame; the first accepted byte after release is parsed as an opcode.

Structure
REQ-031 Opcodes (OP_ID=8'hA5, OP_CHAL=8'h5C) and the state enum SHALL live in shared package puf_cmd_pkg.
REQ-032 The inter-byte timeout SHALL be a sub-module rx_timeout_timer (inputs clear and run; output expired).

Verification
REQ-033 Bench SHALL check this scenario: accept A5 -> one cycle later valid_data_in=1, id_requested=1 for 1 cycle; challenge stays 0.
REQ-034 Bench SHALL check this scenario: accept 5C then 01..08 -> challenge=64'h0102030405060708; valid_data_in=1 and id_requested=0 one cycle after byte 08; busy falls on the same cycle.
REQ-035 Bench SHALL check this scenario: accept 5C plus 3 bytes, then idle TIMEOUT_CYCLES=16 cycles -> cmd_error pulse, state IDLE, challenge unchanged.
REQ-036 Bench SHALL check this scenario: send 5C plus 4 bytes, then rx_error coinciding with rx_valid -> cmd_error one cycle later; a following A5 yields an ID strobe.
REQ-037 Bench SHALL check this scenario: rx_valid with A5 while rx_enable=0 -> no output strobe; byte 33 in IDLE -> cmd_error pulse.
REQ-038 Bench SHALL check this scenario: reset pulled low after 5C plus 2 bytes -> outputs zero immediately; after release, 5C plus 8 bytes completes normally.

Source files
------------

// File: rtl/puf_cmd_pkg.sv
// Shared opcode constants and decoder state encoding for the PUF command path.
package puf_cmd_pkg;

    localparam logic [7:0] OP_ID   = 8'hA5;
    localparam logic [7:0] OP_CHAL = 8'h5C;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

endpackage : puf_cmd_pkg

// File: rtl/rx_timeout_timer.sv
// Inter-byte watchdog: counts cycles while run is high, saturates at the limit,
// and flags expiry once TIMEOUT_CYCLES idle cycles have elapsed since the last clear.
module rx_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule : rx_timeout_timer

// File: rtl/command_decoder.sv
// Parses UART bytes into ID requests and fixed-length challenge frames for the
// main state machine; all strobes are registered single-cycle pulses.
module command_decoder
    import puf_cmd_pkg::*;
#(
    parameter int unsigned CHALLENGE_BYTES = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic                         rx_error,
    input  logic                         rx_enable,
    output logic                         valid_data_in,
    output logic                         id_requested,
    output logic [8*CHALLENGE_BYTES-1:0] challenge,
    output logic                         cmd_error,
    output logic                         busy
);

    localparam int unsigned CHW = 8 * CHALLENGE_BYTES;
    localparam int unsigned BW  = $clog2(CHALLENGE_BYTES + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(CHALLENGE_BYTES - 1);

    state_e         state_q, state_d;
    logic [BW-1:0]  cnt_q, cnt_d;
    logic [CHW-1:0] stage_q, stage_d;
    logic [CHW-1:0] chal_q, chal_d;
    logic           vdi_q, vdi_d;
    logic           id_q, id_d;
    logic           err_q, err_d;

    logic accept;
    logic tmr_clear;
    logic tmr_run;
    logic tmr_expired;

    assign accept = rx_valid && rx_enable && !rx_error;

    // Timer only runs inside a frame; any accepted byte or error restarts it.
    assign tmr_run   = (state_q == ST_COLLECT);
    assign tmr_clear = (state_q != ST_COLLECT) || accept || rx_error;

    rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .run    (tmr_run),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        chal_d  = chal_q;
        vdi_d   = 1'b0;
        id_d    = 1'b0;
        err_d   = 1'b0;

        if (rx_error) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (rx_data == OP_ID) begin
                            vdi_d = 1'b1;
                            id_d  = 1'b1;
                        end else if (rx_data == OP_CHAL) begin
                            state_d = ST_COLLECT;
                            cnt_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        // Earliest byte ends up in the MSBs after the final shift.
                        stage_d = (stage_q << 8) | CHW'(rx_data);
                        cnt_d   = cnt_q + BW'(1);
                        if (cnt_q == LAST_IDX) begin
                            chal_d  = stage_d;
                            vdi_d   = 1'b1;
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else if (tmr_expired) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            chal_q  <= '0;
            vdi_q   <= 1'b0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            chal_q  <= chal_d;
            vdi_q   <= vdi_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign valid_data_in = vdi_q;
    assign id_requested  = id_q;
    assign cmd_error     = err_q;
    assign challenge     = chal_q;
    assign busy          = (state_q == ST_COLLECT);

endmodule : command_decoder

// File: tb/tb_command_decoder.sv
// Scoreboard bench for command_decoder: a behavioural model queues each expected
// strobe with its cycle, and a negedge monitor pops and compares as strobes appear.
module tb_command_decoder;

    localparam int unsigned CB = 8;
    localparam int unsigned TO = 16;

    logic          clk;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_error;
    logic          rx_enable;
    logic          valid_data_in;
    logic          id_requested;
    logic [8*CB-1:0] challenge;
    logic          cmd_error;
    logic          busy;

    command_decoder #(
        .CHALLENGE_BYTES(CB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_error     (rx_error),
        .rx_enable    (rx_enable),
        .valid_data_in(valid_data_in),
        .id_requested (id_requested),
        .challenge    (challenge),
        .cmd_error    (cmd_error),
        .busy         (busy)
    );

    typedef struct {
        logic        vdi;
        logic        id;
        logic        err;
        logic [63:0] chal;
        int          cyc;
    } ev_t;

    ev_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    logic        m_collect;
    int          m_cnt;
    logic [63:0] m_stage;
    logic [63:0] m_chal;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic vdi, input logic id, input logic err, input int at);
        ev_t e;
        e.vdi  = vdi;
        e.id   = id;
        e.err  = err;
        e.chal = m_chal;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_collect = 1'b0;
        m_cnt     = 0;
        m_stage   = '0;
        m_chal    = '0;
    endtask

    // Drives one byte strobe for a single clock and updates the model accordingly.
    task automatic send_byte(input logic [7:0] b, input logic en, input logic err);
        int at;
        @(negedge clk);
        rx_data   = b;
        rx_valid  = 1'b1;
        rx_enable = en;
        rx_error  = err;
        at = cyc + 1;
        if (err) begin
            m_collect = 1'b0;
            m_cnt     = 0;
            push_ev(1'b0, 1'b0, 1'b1, at);
        end else if (en) begin
            if (!m_collect) begin
                if (b == 8'hA5) begin
                    push_ev(1'b1, 1'b1, 1'b0, at);
                end else if (b == 8'h5C) begin
                    m_collect = 1'b1;
                    m_cnt     = 0;
                end else begin
                    push_ev(1'b0, 1'b0, 1'b1, at);
                end
            end else begin
                m_stage = {m_stage[55:0], b};
                m_cnt++;
                if (m_cnt == CB) begin
                    m_chal    = m_stage;
                    m_collect = 1'b0;
                    m_cnt     = 0;
                    push_ev(1'b1, 1'b0, 1'b0, at);
                end
            end
        end
        @(negedge clk);
        rx_valid  = 1'b0;
        rx_error  = 1'b0;
        rx_enable = 1'b1;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (reset && (valid_data_in || id_requested || cmd_error)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_strobe", 64'({valid_data_in, id_requested, cmd_error}), 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("strobe_flags", 64'({valid_data_in, id_requested, cmd_error}),
                         64'({e.vdi, e.id, e.err}));
                check_eq("strobe_cycle", 64'(cyc), 64'(e.cyc));
                check_eq("busy_at_strobe", 64'(busy), 64'd0);
                check_eq("challenge", challenge, e.chal);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        rx_error  = 1'b0;
        rx_enable = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", 64'({valid_data_in, id_requested, cmd_error, busy}), 64'd0);
        check_eq("rst_challenge", challenge, 64'd0);
        reset = 1'b1;

        // ID request from IDLE
        send_byte(8'hA5, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("id_challenge_zero", challenge, 64'd0);

        // Full challenge frame, with a disabled strobe in the middle that must be ignored
        send_byte(8'h5C, 1'b1, 1'b0);
        check_eq("busy_collect", 64'(busy), 64'd1);
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        check_eq("busy_enable_low", 64'(busy), 64'd1);
        for (int i = 3; i <= 8; i++) send_byte(8'(i), 1'b1, 1'b0);
        check_eq("challenge_frame1", challenge, 64'h0102030405060708);

        // Timeout after partial frame
        send_byte(8'h5C, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'hBB, 1'b1, 1'b0);
        send_byte(8'hCC, 1'b1, 1'b0);
        push_ev(1'b0, 1'b0, 1'b1, cyc + TO + 1);
        m_collect = 1'b0;
        m_cnt     = 0;
        repeat (TO + 4) @(negedge clk);
        check_eq("busy_after_timeout", 64'(busy), 64'd0);
        check_eq("challenge_after_timeout", challenge, 64'h0102030405060708);

        // rx_error coinciding with a byte aborts the frame, then an ID request works
        send_byte(8'h5C, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b0);
        send_byte(8'h5C, 1'b1, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h33, 1'b1, 1'b1);
        check_eq("busy_after_rx_error", 64'(busy), 64'd0);
        send_byte(8'hA5, 1'b1, 1'b0);

        // Disabled ID byte is ignored; an illegal opcode errors
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0);

        // Reset mid-frame, then a clean frame
        send_byte(8'h5C, 1'b1, 1'b0);
        send_byte(8'hDE, 1'b1, 1'b0);
        send_byte(8'hAD, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_eq("midrst_outputs", 64'({valid_data_in, id_requested, cmd_error, busy}), 64'd0);
        check_eq("midrst_challenge", challenge, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        send_byte(8'h5C, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(8'hF0 + 8'(i), 1'b1, 1'b0);
        check_eq("challenge_frame2", challenge, 64'hF0F1F2F3F4F5F6F7);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check_eq("sb_drain", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_command_decoder
